// File: rtl/mem_arbiter.sv
// Byte-serial sequencer that shares one byte-wide RAM port between instruction fetch and
// load/store traffic, with round-robin ties, IO back-pressure on writes and flush of reads.
module mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int IO_HI      = 17
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rdy,
   input  logic                  Clear_flag,
   input  logic                  ins_req,
   input  logic [ADDR_WIDTH-1:0] ins_addr,
   output logic                  ins_ok,
   output logic [31:0]           ins_data,
   input  logic                  data_req,
   input  logic                  data_we,
   input  logic [1:0]            data_len,
   input  logic [ADDR_WIDTH-1:0] data_addr,
   input  logic [31:0]           data_wdata,
   output logic                  data_ok,
   output logic [31:0]           data_rdata,
   input  logic [7:0]            mem_din,
   output logic [7:0]            mem_dout,
   output logic [ADDR_WIDTH-1:0] mem_a,
   output logic                  mem_wr,
   input  logic                  io_buffer_full
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   localparam logic GRANT_FETCH = 1'b0;
   localparam logic GRANT_DATA  = 1'b1;

   state_t                state, state_n;
   logic [2:0]            cnt, cnt_n;
   logic [2:0]            nbytes, nbytes_n;
   logic [ADDR_WIDTH-1:0] addr, addr_n;
   logic [31:0]           wdata, wdata_n;
   logic [31:0]           rbuf, rbuf_n;
   logic                  is_fetch, is_fetch_n;
   logic                  is_store, is_store_n;
   logic                  last_grant, last_grant_n;

   logic                  grant_fetch, grant_data;
   logic                  io_stall;
   logic [1:0]            cap_idx;

   // A tie goes to whichever side did not win the previous grant.
   assign grant_fetch = ins_req && (!data_req || last_grant == GRANT_DATA);
   assign grant_data  = data_req && !grant_fetch;
   assign io_stall    = (addr[IO_HI:IO_HI-1] == 2'b11) && io_buffer_full;
   assign cap_idx     = 2'(cnt - 3'd1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         nbytes     <= '0;
         addr       <= '0;
         wdata      <= '0;
         rbuf       <= '0;
         is_fetch   <= 1'b0;
         is_store   <= 1'b0;
         last_grant <= GRANT_DATA;
      end else if (rdy) begin
         state      <= state_n;
         cnt        <= cnt_n;
         nbytes     <= nbytes_n;
         addr       <= addr_n;
         wdata      <= wdata_n;
         rbuf       <= rbuf_n;
         is_fetch   <= is_fetch_n;
         is_store   <= is_store_n;
         last_grant <= last_grant_n;
      end
   end

   always_comb begin
      state_n      = state;
      cnt_n        = cnt;
      nbytes_n     = nbytes;
      addr_n       = addr;
      wdata_n      = wdata;
      rbuf_n       = rbuf;
      is_fetch_n   = is_fetch;
      is_store_n   = is_store;
      last_grant_n = last_grant;
      ins_ok       = 1'b0;
      ins_data     = '0;
      data_ok      = 1'b0;
      data_rdata   = '0;
      mem_a        = '0;
      mem_dout     = '0;
      mem_wr       = 1'b0;

      case (state)
         IDLE: begin
            cnt_n  = '0;
            rbuf_n = '0;
            // A flush drops anything that would be granted in this cycle.
            if (!Clear_flag) begin
               if (grant_fetch) begin
                  is_fetch_n   = 1'b1;
                  is_store_n   = 1'b0;
                  addr_n       = ins_addr;
                  nbytes_n     = 3'd4;
                  last_grant_n = GRANT_FETCH;
                  state_n      = READ;
               end else if (grant_data) begin
                  is_fetch_n   = 1'b0;
                  is_store_n   = data_we;
                  addr_n       = data_addr;
                  wdata_n      = data_wdata;
                  nbytes_n     = (data_len == 2'd0) ? 3'd1 : (data_len == 2'd1) ? 3'd2 : 3'd4;
                  last_grant_n = GRANT_DATA;
                  state_n      = data_we ? WRITE : READ;
               end
            end
         end
         READ: begin
            if (cnt < nbytes) mem_a = addr + ADDR_WIDTH'(cnt);
            // The byte addressed in the previous cycle arrives on mem_din now.
            if (cnt != 3'd0) rbuf_n[{cap_idx, 3'b000} +: 8] = mem_din;
            if (Clear_flag) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else if (cnt == nbytes) begin
               state_n = DONE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 3'd1;
            end
         end
         WRITE: begin
            mem_a    = addr + ADDR_WIDTH'(cnt);
            mem_dout = wdata[{cnt[1:0], 3'b000} +: 8];
            mem_wr   = !io_stall;
            if (!io_stall) begin
               if (cnt == nbytes - 3'd1) begin
                  state_n = DONE;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt + 3'd1;
               end
            end
         end
         DONE: begin
            if (is_fetch) begin
               ins_ok   = rdy && !Clear_flag;
               ins_data = ins_ok ? rbuf : '0;
            end else begin
               data_ok    = rdy && (is_store || !Clear_flag);
               data_rdata = (data_ok && !is_store) ? rbuf : '0;
            end
            state_n = IDLE;
            cnt_n   = '0;
         end
         default: state_n = IDLE;
      endcase

      if (!rdy) mem_wr = 1'b0;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: byte RAM model, result and write scoreboards, latency checks.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst, rdy, Clear_flag;
   logic        ins_req, data_req, data_we;
   logic [31:0] ins_addr, data_addr, data_wdata;
   logic [1:0]  data_len;
   logic        ins_ok, data_ok, mem_wr, io_buffer_full;
   logic [31:0] ins_data, data_rdata, mem_a;
   logic [7:0]  mem_din, mem_dout;

   int n_assert = 0;
   int n_fail   = 0;
   int n_writes = 0;

   logic [31:0] exp_ins_q[$];
   logic [31:0] exp_data_q[$];
   logic [39:0] exp_wr_q[$];
   logic [31:0] addr_log[0:15];
   logic [7:0]  ram[0:262143];

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk(clk), .rst(rst), .rdy(rdy), .Clear_flag(Clear_flag),
      .ins_req(ins_req), .ins_addr(ins_addr), .ins_ok(ins_ok), .ins_data(ins_data),
      .data_req(data_req), .data_we(data_we), .data_len(data_len), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_ok(data_ok), .data_rdata(data_rdata),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full)
   );

   // Synchronous RAM, 1-cycle read latency, enabled by the same global rdy as the arbiter.
   always @(posedge clk) begin
      if (rdy) begin
         mem_din <= ram[mem_a[17:0]];
         if (mem_wr) ram[mem_a[17:0]] = mem_dout;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Result and write scoreboards, sampled mid-cycle.
   always @(negedge clk) begin
      if (ins_ok) begin
         if (exp_ins_q.size() == 0) chk("ins_ok_unexpected", 32'd1, 32'd0);
         else chk("ins_data", ins_data, exp_ins_q.pop_front());
      end
      if (data_ok && !data_we) begin
         if (exp_data_q.size() == 0) chk("data_ok_unexpected", 32'd1, 32'd0);
         else chk("data_rdata", data_rdata, exp_data_q.pop_front());
      end
      if (mem_wr) begin
         n_writes++;
         chk("io_gate", 32'(io_buffer_full && mem_a[17:16] == 2'b11), 32'd0);
         if (exp_wr_q.size() == 0) chk("write_unexpected", mem_a, 32'hFFFF_FFFF);
         else chk("write_addr_data", {mem_a[23:0], mem_dout}, exp_wr_q.pop_front()[31:0]);
      end
   end

   task automatic do_reset();
      rst = 1'b1; rdy = 1'b1; Clear_flag = 1'b0; ins_req = 1'b0; data_req = 1'b0;
      data_we = 1'b0; data_len = 2'd0; ins_addr = '0; data_addr = '0; data_wdata = '0;
      io_buffer_full = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Issue one request at the start of an IDLE cycle; lat = cycle index of its ok pulse.
   task automatic run(input bit fetch, input bit we, input logic [1:0] len,
                      input logic [31:0] a, input logic [31:0] wd, output int lat);
      lat = -1;
      if (fetch) begin
         ins_req = 1'b1; ins_addr = a;
      end else begin
         data_req = 1'b1; data_we = we; data_len = len; data_addr = a; data_wdata = wd;
      end
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (c < 16) addr_log[c] = mem_a;
         if (fetch ? ins_ok : data_ok) begin
            lat = c;
            break;
         end
      end
      if (lat < 0) chk("ok_timeout", 32'd0, 32'd1);
      ins_req = 1'b0; data_req = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic tie(output int t_ins, output int t_data);
      t_ins = -1; t_data = -1;
      ins_req = 1'b1; ins_addr = 32'h0;
      data_req = 1'b1; data_we = 1'b0; data_len = 2'd1; data_addr = 32'h1000;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (ins_ok) begin t_ins = c; ins_req = 1'b0; end
         if (data_ok) begin t_data = c; data_req = 1'b0; end
         if (t_ins >= 0 && t_data >= 0) break;
      end
      if (t_ins < 0 || t_data < 0) chk("tie_timeout", 32'd0, 32'd1);
      ins_req = 1'b0; data_req = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int lat, ti, td, w0;
      logic [31:0] rv;
      foreach (ram[i]) ram[i] = 8'h00;
      ram[0] = 8'h13; ram[1] = 8'h05;
      ram[18'h1000] = 8'hFF; ram[18'h1001] = 8'h80;
      ram[18'h3000] = 8'h78; ram[18'h3001] = 8'h56; ram[18'h3002] = 8'h34; ram[18'h3003] = 8'h12;
      mem_din = 8'h00;

      do_reset();
      @(negedge clk);
      chk("rst_mem_a", mem_a, 32'h0);
      chk("rst_mem_wr", 32'(mem_wr), 32'h0);
      chk("rst_mem_dout", 32'(mem_dout), 32'h0);
      chk("rst_ins_ok", 32'(ins_ok), 32'h0);
      chk("rst_data_ok", 32'(data_ok), 32'h0);
      chk("rst_ins_data", ins_data, 32'h0);
      chk("rst_data_rdata", data_rdata, 32'h0);
      @(posedge clk); #1;

      // Tie straight after reset: fetch first, then the halfword load, then fetch wins again.
      exp_ins_q.push_back(32'h0000_0513);
      exp_data_q.push_back(32'h0000_80FF);
      tie(ti, td);
      chk("tie1_ins_cycle", 32'(ti), 32'd6);
      chk("tie1_data_cycle", 32'(td), 32'd11);
      exp_ins_q.push_back(32'h0000_0513);
      exp_data_q.push_back(32'h0000_80FF);
      tie(ti, td);
      chk("tie2_fetch_first", 32'(ti < td), 32'd1);

      // Plain fetch: address walk and latency.
      exp_ins_q.push_back(32'h0000_0513);
      run(1'b1, 1'b0, 2'd0, 32'h0, 32'h0, lat);
      chk("fetch_lat", 32'(lat), 32'd6);
      for (int k = 1; k <= 4; k++) chk("fetch_mem_a", addr_log[k], 32'(k - 1));
      chk("fetch_idle_a", addr_log[0], 32'h0);

      // Word store.
      for (int k = 0; k < 4; k++) begin
         rv = 32'hDEADBEEF >> (8 * k);
         exp_wr_q.push_back({8'h0, 24'h2000 + 24'(k), rv[7:0]});
      end
      w0 = n_writes;
      run(1'b0, 1'b1, 2'd2, 32'h2000, 32'hDEADBEEF, lat);
      chk("sw_lat", 32'(lat), 32'd5);
      chk("sw_writes", 32'(n_writes - w0), 32'd4);

      // IO byte store held off by a full buffer for three cycles.
      exp_wr_q.push_back({8'h0, 24'h030000, 8'h41});
      io_buffer_full = 1'b1;
      fork
         begin repeat (4) @(posedge clk); #1 io_buffer_full = 1'b0; end
      join_none
      w0 = n_writes;
      run(1'b0, 1'b1, 2'd0, 32'h30000, 32'h0000_0041, lat);
      chk("io_lat", 32'(lat), 32'd5);
      chk("io_writes", 32'(n_writes - w0), 32'd1);

      // Flush in fetch cycle 3: no ok, idle in cycle 4, next fetch is unaffected.
      ins_req = 1'b1; ins_addr = 32'h0;
      repeat (3) @(posedge clk);
      #1 Clear_flag = 1'b1; ins_req = 1'b0;
      @(posedge clk);
      #1 Clear_flag = 1'b0;
      @(negedge clk);
      chk("flush_idle_a", mem_a, 32'h0);
      chk("flush_no_ok", 32'(ins_ok), 32'h0);
      repeat (6) @(negedge clk);
      @(posedge clk); #1;
      exp_ins_q.push_back(32'h0000_0513);
      run(1'b1, 1'b0, 2'd0, 32'h0, 32'h0, lat);
      chk("post_flush_lat", 32'(lat), 32'd6);

      // Flush in the middle of a store: it still completes in full.
      for (int k = 0; k < 4; k++) exp_wr_q.push_back({8'h0, 24'h2010 + 24'(k), 8'hA0 + 8'(k)});
      fork
         begin repeat (2) @(posedge clk); #1 Clear_flag = 1'b1; @(posedge clk); #1 Clear_flag = 1'b0; end
      join_none
      w0 = n_writes;
      run(1'b0, 1'b1, 2'd2, 32'h2010, 32'hA3A2A1A0, lat);
      chk("flush_sw_lat", 32'(lat), 32'd5);
      chk("flush_sw_writes", 32'(n_writes - w0), 32'd4);

      // Two-cycle freeze in a word load.
      exp_data_q.push_back(32'h1234_5678);
      fork
         begin
            repeat (2) @(posedge clk); #1 rdy = 1'b0;
            @(negedge clk); chk("freeze_a_c2", mem_a, 32'h3001);
            chk("freeze_wr", 32'(mem_wr), 32'h0);
            @(negedge clk); chk("freeze_a_c3", mem_a, 32'h3001);
            @(posedge clk); #1 rdy = 1'b1;
         end
      join_none
      run(1'b0, 1'b0, 2'd2, 32'h3000, 32'h0, lat);
      chk("freeze_lat", 32'(lat), 32'd8);

      // Reset in the middle of a store leaves the first two bytes written.
      exp_wr_q.push_back({8'h0, 24'h2100, 8'h44});
      exp_wr_q.push_back({8'h0, 24'h2101, 8'h33});
      data_req = 1'b1; data_we = 1'b1; data_len = 2'd2; data_addr = 32'h2100; data_wdata = 32'h11223344;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1; data_req = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_wr", 32'(mem_wr), 32'h0);
      chk("rst_mid_a", mem_a, 32'h0);
      chk("rst_mid_ok", 32'(data_ok), 32'h0);
      chk("rst_mid_ram", 32'(ram[18'h2102]), 32'h0);
      @(posedge clk); #1;

      chk("ins_q_empty", 32'(exp_ins_q.size()), 32'd0);
      chk("data_q_empty", 32'(exp_data_q.size()), 32'd0);
      chk("wr_q_empty", 32'(exp_wr_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
